npu_bias_act_stage: RTL

Post-accumulation stage of the NPU datapath, sitting directly downstream of the MAC array and directly in front of `npu_bias_rom_top`'s consumers. It accepts one 32-lane accumulator vector per transaction tagged with a layer index, fetches that layer's 32 biases from the bias ROM, and adds them lane-wise. It then rescales, applies ReLU and saturates each lane to a 16-bit activation, and hands the result downstream over a valid/ready handshake.

---
 rtl/npu_bias_act_stage_if.sv | 29 ++
 rtl/npu_bias_act_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/npu_bias_act_stage_if.sv
// Bundle of the accumulator input, bias ROM port and activation output handshakes
// for npu_bias_act_stage; slave is the stage's view, master the surrounding fabric's.
interface npu_bias_act_stage_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int LANES      = 32
) ();
   logic                        acc_valid;
   logic                        acc_ready;
   logic [2:0]                  acc_layer;
   logic [LANES*ACC_WIDTH-1:0]  acc_data;
   logic [2:0]                  bias_rom_rd_addr;
   logic [LANES*DATA_WIDTH-1:0] bias_rom_rd_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [2:0]                  out_layer;
   logic [LANES*DATA_WIDTH-1:0] out_data;
   logic                        out_sat;

   modport slave (
      input  acc_valid, acc_layer, acc_data, bias_rom_rd_data, out_ready,
      output acc_ready, bias_rom_rd_addr, out_valid, out_layer, out_data, out_sat
   );

   modport master (
      output acc_valid, acc_layer, acc_data, bias_rom_rd_data, out_ready,
      input  acc_ready, bias_rom_rd_addr, out_valid, out_layer, out_data, out_sat
   );
endinterface

// File: rtl/npu_bias_act_stage.sv
// Post-accumulation bias add, rescale, optional ReLU and 16-bit saturation for 32 lanes.
// Define NPU_BIAS_RELU_EN for the ReLU build; leave it undefined for the linear (logits) build.
module npu_bias_act_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int FRAC_BITS  = 8
) (
   input logic                clk,
   input logic                rst_n,
   npu_bias_act_stage_if.slave bus
);
   localparam int LANES = 32;
   localparam int SUM_W = ACC_WIDTH + 2;

   localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'((2**(DATA_WIDTH-1)) - 1);
   localparam logic signed [SUM_W-1:0] C_MIN = -C_MAX - SUM_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ADD,
      ST_OUT
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        w_accept;
   logic                        w_load_out;

   logic [LANES*ACC_WIDTH-1:0]  r_acc;
   logic [2:0]                  r_rom_addr;
   logic [2:0]                  r_out_layer;
   logic [LANES*DATA_WIDTH-1:0] r_out_data;
   logic                        r_out_sat;

   logic signed [SUM_W-1:0]     w_acc_ext;
   logic signed [SUM_W-1:0]     w_bias_ext;
   logic signed [SUM_W-1:0]     w_sum;
   logic signed [SUM_W-1:0]     w_r;
   logic [LANES*DATA_WIDTH-1:0] w_lane_act;
   logic [LANES-1:0]            w_lane_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load_out  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.acc_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: w_state_nxt = ST_ADD;
         ST_ADD: begin
            w_load_out  = 1'b1;
            w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bias is Q.FRAC_BITS, accumulator Q.(2*FRAC_BITS): align, add, then drop FRAC_BITS.
   always_comb begin
      w_acc_ext  = '0;
      w_bias_ext = '0;
      w_sum      = '0;
      w_r        = '0;
      w_lane_act = '0;
      w_lane_sat = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         w_acc_ext  = {{(SUM_W-ACC_WIDTH){r_acc[ACC_WIDTH*j + ACC_WIDTH-1]}},
                       r_acc[ACC_WIDTH*j +: ACC_WIDTH]};
         w_bias_ext = {{(SUM_W-DATA_WIDTH){bus.bias_rom_rd_data[DATA_WIDTH*j + DATA_WIDTH-1]}},
                       bus.bias_rom_rd_data[DATA_WIDTH*j +: DATA_WIDTH]};
         w_sum      = w_acc_ext + (w_bias_ext <<< FRAC_BITS);
         w_r        = w_sum >>> FRAC_BITS;
`ifdef NPU_BIAS_RELU_EN
         if (w_r[SUM_W-1]) begin
            w_r = '0;
         end
         if (w_r > C_MAX) begin
            w_lane_act[DATA_WIDTH*j +: DATA_WIDTH] = C_MAX[DATA_WIDTH-1:0];
            w_lane_sat[j]                          = 1'b1;
         end else begin
            w_lane_act[DATA_WIDTH*j +: DATA_WIDTH] = w_r[DATA_WIDTH-1:0];
         end
`else
         if (w_r > C_MAX) begin
            w_lane_act[DATA_WIDTH*j +: DATA_WIDTH] = C_MAX[DATA_WIDTH-1:0];
            w_lane_sat[j]                          = 1'b1;
         end else if (w_r < C_MIN) begin
            w_lane_act[DATA_WIDTH*j +: DATA_WIDTH] = C_MIN[DATA_WIDTH-1:0];
            w_lane_sat[j]                          = 1'b1;
         end else begin
            w_lane_act[DATA_WIDTH*j +: DATA_WIDTH] = w_r[DATA_WIDTH-1:0];
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_rom_addr  <= '0;
         r_out_layer <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_acc       <= bus.acc_data;
            r_rom_addr  <= bus.acc_layer;
            r_out_layer <= bus.acc_layer;
         end
         if (w_load_out) begin
            r_out_data <= w_lane_act;
            r_out_sat  <= |w_lane_sat;
         end
      end
   end

   assign bus.acc_ready        = (r_state == ST_IDLE);
   assign bus.out_valid        = (r_state == ST_OUT);
   assign bus.bias_rom_rd_addr = r_rom_addr;
   assign bus.out_layer        = r_out_layer;
   assign bus.out_data         = r_out_data;
   assign bus.out_sat          = r_out_sat;
endmodule
